// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU opcode encoding and small helpers shared by the E-stage multiply/divide unit.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit holding HI/LO, with fixed-latency mult/div and Busy for the hazard unit.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  opMDU,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDUresult
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   temp_hi;
    logic [31:0]   temp_lo;
    logic [CW-1:0] count;
    logic          commit_ok;

    logic          op_div;
    logic          op_signed;
    logic          div_zero;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   product;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   safe_b;
    logic [31:0]   quot_mag;
    logic [31:0]   rem_mag;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    assign op_div    = is_divide(opMDU);
    assign op_signed = is_signed_op(opMDU);
    assign div_zero  = (SrcB == 32'd0);
    assign Start     = is_muldiv(opMDU) && !Req;

    // Sign-extending to 64 bits lets one unsigned multiplier produce both signed and unsigned products.
    assign ext_a   = {{32{op_signed & SrcA[31]}}, SrcA};
    assign ext_b   = {{32{op_signed & SrcB[31]}}, SrcB};
    assign product = ext_a * ext_b;

    // Divide on magnitudes, then restore signs; this also makes 0x80000000 / -1 wrap to 0x80000000.
    assign mag_a    = (op_signed && SrcA[31]) ? (32'd0 - SrcA) : SrcA;
    assign mag_b    = (op_signed && SrcB[31]) ? (32'd0 - SrcB) : SrcB;
    assign safe_b   = div_zero ? 32'd1 : mag_b;
    assign quot_mag = mag_a / safe_b;
    assign rem_mag  = mag_a % safe_b;
    assign quot     = (op_signed && (SrcA[31] ^ SrcB[31])) ? (32'd0 - quot_mag) : quot_mag;
    assign rem      = (op_signed && SrcA[31]) ? (32'd0 - rem_mag) : rem_mag;

    assign res_hi = op_div ? rem  : product[63:32];
    assign res_lo = op_div ? quot : product[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi        <= 32'd0;
            lo        <= 32'd0;
            temp_hi   <= 32'd0;
            temp_lo   <= 32'd0;
            count     <= '0;
            commit_ok <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            if (Start && !Busy) begin
                temp_hi   <= res_hi;
                temp_lo   <= res_lo;
                commit_ok <= !(op_div && div_zero);
                count     <= op_div ? DIV_LOAD : MULT_LOAD;
                Busy      <= 1'b1;
            end else if (count != '0) begin
                count <= count - 1'b1;
                if (count == CW'(1)) begin
                    Busy <= 1'b0;
                    if (commit_ok) begin
                        hi <= temp_hi;
                        lo <= temp_lo;
                    end
                end
            end

            // Moves never coincide with a commit: a commit only happens while Busy is high.
            if (!Req && !Busy) begin
                if (opMDU == MDU_MTHI) begin
                    hi <= SrcA;
                end
                if (opMDU == MDU_MTLO) begin
                    lo <= SrcA;
                end
            end
        end
    end

    always_comb begin
        MDUresult = 32'd0;
        if (opMDU == MDU_MFHI) begin
            MDUresult = hi;
        end else if (opMDU == MDU_MFLO) begin
            MDUresult = lo;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - Directed and random checks of e_mdu against an arithmetic HI/LO reference model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [3:0]  opMDU;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Start;
    logic        Busy;
    logic [31:0] MDUresult;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .Req(Req),
        .opMDU(opMDU),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .Start(Start),
        .Busy(Busy),
        .MDUresult(MDUresult)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(Start && Busy)) else begin
                errors++;
                $error("FAIL protocol start_while_busy observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic expect_start(input logic [3:0] op, input logic req);
        return !req && (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU});
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
        longint          sa;
        longint          sb;
        longint          p;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        if (!req) begin
            case (op)
                MDU_MULT:  begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
                MDU_MULTU: begin up = ua * ub; hi_m = up[63:32]; lo_m = up[31:0]; end
                MDU_DIV:   if (b != 0) begin p = sa / sb; r = sa % sb; lo_m = p[31:0]; hi_m = r[31:0]; end
                MDU_DIVU:  if (b != 0) begin lo_m = a / b; hi_m = a % b; end
                MDU_MTHI:  hi_m = a;
                MDU_MTLO:  lo_m = a;
                default:   ;
            endcase
        end
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic req, input string tag);
        @(negedge clk);
        opMDU = op; SrcA = a; SrcB = b; Req = req;
        #1;
        chk({tag, " start"}, 32'(Start), 32'(expect_start(op, req)));
        @(posedge clk);
        #1;
        opMDU = MDU_NONE; Req = 1'b0;
    endtask

    task automatic wait_busy(input int n, input int req_at, input string tag);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            Req = (i == req_at);
            chk($sformatf("%s busy%0d", tag, i), 32'(Busy), 32'd1);
        end
        @(posedge clk);
        #1;
        Req = 1'b0;
        chk({tag, " busy_end"}, 32'(Busy), 32'd0);
    endtask

    task automatic read_hilo(input string tag);
        @(negedge clk);
        opMDU = MDU_MFHI;
        #1;
        chk({tag, " hi"}, MDUresult, hi_m);
        @(negedge clk);
        opMDU = MDU_MFLO;
        #1;
        chk({tag, " lo"}, MDUresult, lo_m);
        opMDU = MDU_NONE;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic req, input int req_at, input string tag);
        start_op(op, a, b, req, tag);
        if (expect_start(op, req)) begin
            wait_busy((op inside {MDU_DIV, MDU_DIVU}) ? DC : MC, req_at, tag);
        end else begin
            chk({tag, " no_busy"}, 32'(Busy), 32'd0);
        end
        model(op, a, b, req);
        read_hilo(tag);
    endtask

    initial begin
        logic [3:0]  ops [6];
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        req;

        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
        reset = 1'b1; Req = 1'b0; opMDU = MDU_NONE; SrcA = 32'd0; SrcB = 32'd0;
        #12;
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset start", 32'(Start), 32'd0);
        opMDU = MDU_MFHI;
        #1;
        chk("reset hi", MDUresult, 32'd0);
        opMDU = MDU_MFLO;
        #1;
        chk("reset lo", MDUresult, 32'd0);
        opMDU = MDU_NONE;
        @(negedge clk);
        reset = 1'b0;

        run_op(MDU_MTLO, 32'h0000_0055, 32'd0, 1'b0, -1, "pre_mtlo");
        start_op(MDU_MULT, 32'd3, 32'd4, 1'b0, "mid_mult");
        @(posedge clk);
        #2;
        reset = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        #1;
        chk("mid_reset busy", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset busy", 32'(Busy), 32'd0);
        read_hilo("post_reset");

        run_op(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0, -1, "mthi");
        run_op(MDU_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, "mult");
        chk("mult hi const", hi_m, 32'hFFFF_FFFF);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, "multu");
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, -1, "div");
        run_op(MDU_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 1'b0, -1, "divu");

        run_op(MDU_MTHI, 32'hAAAA_0000, 32'd0, 1'b0, -1, "set_hi");
        run_op(MDU_MTLO, 32'h0000_BBBB, 32'd0, 1'b0, -1, "set_lo");
        run_op(MDU_DIV,  32'h1234_0000, 32'd0, 1'b0, -1, "div0");
        run_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, "div_ovf");

        run_op(MDU_MULT, 32'd7, 32'd9, 1'b1, -1, "flush_mult");
        run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1, -1, "flush_mthi");
        run_op(MDU_DIV,  32'hFFFF_FF00, 32'd7, 1'b0, 2, "div_req3");

        start_op(MDU_DIV, 32'd100, 32'd7, 1'b0, "b2b_div");
        wait_busy(DC, -1, "b2b_div");
        model(MDU_DIV, 32'd100, 32'd7, 1'b0);
        start_op(MDU_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0, "b2b_mult");
        opMDU = MDU_MFHI;
        for (int i = 0; i < MC; i++) begin
            if (i > 0) begin
                @(posedge clk);
            end
            #1;
            chk($sformatf("b2b busy%0d", i), 32'(Busy), 32'd1);
            chk($sformatf("b2b old_hi%0d", i), MDUresult, hi_m);
        end
        @(posedge clk);
        #1;
        model(MDU_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0);
        chk("b2b busy_end", 32'(Busy), 32'd0);
        chk("b2b new_hi", MDUresult, hi_m);
        opMDU = MDU_NONE;
        read_hilo("b2b_mult");

        for (int k = 0; k < 30; k++) begin
            op  = ops[$urandom_range(0, 5)];
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                b = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) begin
                    b = 32'd0 - b;
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                b = 32'd0;
            end
            req = ($urandom_range(0, 7) == 0);
            run_op(op, a, b, req, -1, $sformatf("rand%0d_op%0d", k, op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, beside the ALU.
- Takes the same forwarded SrcA/SrcB operands and executes mult/multu/div/divu with fixed multi-cycle latency.
- Holds the architectural HI/LO registers and serves mthi/mtlo/mfhi/mflo.
- Drives Busy to the hazard unit, which stalls D while an MDU op is in flight or starting.

Parameters:
- MULT_CYCLES, 5, Busy cycles after a mult/multu start.
- DIV_CYCLES, 10, Busy cycles after a div/divu start.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Req  input  1  exception/interrupt flush of the E instruction; when high, the E op has no effect.
- opMDU  input  4  operation: MDU_none, MDU_mult, MDU_multu, MDU_div, MDU_divu, MDU_mthi, MDU_mtlo, MDU_mfhi, MDU_mflo.
- SrcA  input  32  rs operand, forwarded.
- SrcB  input  32  rt operand, forwarded.
- Start  output  1  combinational; high when opMDU is mult/multu/div/divu and Req=0.
- Busy  output  1  registered; high while an operation is in flight.
- MDUresult  output  32  combinational; HI for mfhi, LO for mflo, else 0.

Behaviour:
- Reset (async):
  - HI, LO, temp HI/LO and counter go to 0.
  - Busy=0; MDUresult reads 0.
- Start edge (Start=1, Busy=0):
  - Compute the full result into tempHI/tempLO.
  - Load counter with MULT_CYCLES or DIV_CYCLES; Busy goes high the next cycle.
- Counting:
  - Counter decrements each edge while nonzero.
  - On the edge where counter==1: HI<=tempHI, LO<=tempLO, counter<=0.
  - Busy is therefore high for exactly N cycles after the start edge. The new HI/LO is visible the cycle Busy falls.
- Arithmetic:
  - mult: signed 32x32->64, HI=upper, LO=lower.
  - multu: unsigned 32x32->64.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero: Busy runs the full DIV_CYCLES, and HI/LO are left unchanged.
- mthi/mtlo:
  - Write HI/LO from SrcA at the edge when Req=0 and Busy=0.
  - They take one cycle and do not raise Busy.
- mfhi/mflo:
  - MDUresult is combinational from the architectural HI/LO.
  - The hazard unit guarantees no read while Busy.
- Start while Busy: ignored; the in-flight op completes unchanged. This is a protocol error upstream, and the bench asserts it never occurs.
- Req=1: suppresses Start and mthi/mtlo that cycle. An op already in flight continues to completion, because it was committed by an older instruction.
- Reset mid-operation: abandons the op; HI/LO go to 0.
- Counter width: enough for max(MULT_CYCLES, DIV_CYCLES); 4 bits at defaults.

Decomposition:
- MDU_* opcode constants go in the shared Define.v, alongside ALU_*.
- Single module; no sub-module needed. The counter and result latch are small.
- The stall equation (Start|Busy with a D-stage MDU instruction) lives in the hazard unit, not here.

Test Plan:
- Reset and mthi:
  - Reset mid-mult -> Busy=0, HI=LO=0 next cycle.
  - Then mthi SrcA=0x12345678 -> mfhi returns 0x12345678 one cycle later, with Busy never high.
- Signed and unsigned multiply:
  - mult 0xFFFFFFFF x 0x00000002 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide:
  - div 0xFFFFFFF9 (-7) / 0x00000002 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero and overflow:
  - With HI=0xAAAA0000, LO=0x0000BBBB, div x/0 -> Busy 10 cycles, HI/LO unchanged.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Flush:
  - Req=1 with opMDU=mult -> Start=0, Busy stays 0, HI/LO unchanged.
  - Req=1 asserted at cycle 3 of an in-flight div -> op still completes with correct HI/LO.
- Back-to-back:
  - mult start the same cycle Busy falls from a prior div -> accepted.
  - HI/LO show the div result for 5 cycles, then the mult result.
